// File: rtl/memory_pkg.sv
// Shared types and ROM contents for the instruction memory.
// Default widths, the pc type and the fixed ROM pattern.
package memory_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ROM_DEPTH_DEF = 2 ** ADDR_W_DEF;

    typedef logic [ADDR_W_DEF-1:0] pc_t;
    typedef logic [ROM_DEPTH_DEF-1:0][DATA_W_DEF-1:0] rom_t;

    // {idx, ~idx} over aw bits; callers truncate or zero-extend to DATA_W
    function automatic logic [63:0] rom_entry(input int unsigned aw,
                                              input int unsigned idx);
        logic [63:0] m;
        logic [63:0] v;
        m = (64'd1 << aw) - 64'd1;
        v = 64'(idx) & m;
        return (v << aw) | (~v & m);
    endfunction

    function automatic rom_t rom_init();
        rom_t t;
        for (int i = 0; i < ROM_DEPTH_DEF; i++) begin
            t[i] = DATA_W_DEF'(rom_entry(ADDR_W_DEF, i));
        end
        return t;
    endfunction

endpackage

// File: rtl/memory_pc_reg.sv
// Program counter: async active-low clear, branch load, else increment.
// Increment wraps naturally at 2**ADDR_W.
module pc_reg
    import memory_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branchaddress,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_nxt;

    always_comb begin
        pc_nxt = pc + ADDR_W'(1);
        if (branch) begin
            pc_nxt = branchaddress;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/memory.sv
// Instruction memory: program counter plus fixed combinational ROM.
// instruction follows pc with zero clock latency.
module memory
    import memory_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branchaddress,
    output logic [DATA_W-1:0] instruction
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] rom [DEPTH];

    pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .branch        (branch),
        .branchaddress (branchaddress),
        .pc            (pc)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = DATA_W'(rom_entry(ADDR_W, g));
    end

    assign instruction = rom[pc];

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: reset, counting, branches, wrap, async reset.
// Outputs are sampled on the falling edge or between edges.
module tb_memory;

    logic       clk;
    logic       rst;
    logic       branch;
    logic [3:0] branchaddress;
    logic [7:0] instruction;

    int n_checks = 0;
    int n_fail = 0;

    memory uut (
        .clk           (clk),
        .rst           (rst),
        .branch        (branch),
        .branchaddress (branchaddress),
        .instruction   (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pc_ins(input string tag, input logic [3:0] p,
                          input logic [7:0] ins);
        check({tag, "_pc"}, 32'(uut.pc), 32'(p));
        check({tag, "_ins"}, 32'(instruction), 32'(ins));
    endtask

    task automatic edge_chk(input string tag, input logic [3:0] p,
                            input logic [7:0] ins);
        @(negedge clk);
        pc_ins(tag, p, ins);
    endtask

    initial begin
        rst = 1'b1;
        branch = 1'b0;
        branchaddress = 4'd0;
        #3 rst = 1'b0;
        #5 pc_ins("rst", 4'd0, 8'h0F);
        #5 rst = 1'b1;

        edge_chk("cnt1", 4'd1, 8'h1E);
        edge_chk("cnt2", 4'd2, 8'h2D);
        edge_chk("cnt3", 4'd3, 8'h3C);
        edge_chk("cnt4", 4'd4, 8'h4B);

        branch = 1'b1;
        branchaddress = 4'd2;
        edge_chk("br2", 4'd2, 8'h2D);
        branch = 1'b0;
        edge_chk("br2_r3", 4'd3, 8'h3C);
        edge_chk("br2_r4", 4'd4, 8'h4B);
        edge_chk("br2_r5", 4'd5, 8'h5A);

        branch = 1'b1;
        branchaddress = 4'd0;
        edge_chk("br0", 4'd0, 8'h0F);
        branch = 1'b0;
        edge_chk("br0_r1", 4'd1, 8'h1E);

        branch = 1'b1;
        branchaddress = 4'd14;
        edge_chk("br14", 4'd14, 8'hE1);
        branch = 1'b0;
        edge_chk("cnt15", 4'd15, 8'hF0);
        edge_chk("wrap0", 4'd0, 8'h0F);
        edge_chk("wrap1", 4'd1, 8'h1E);

        branch = 1'b1;
        branchaddress = 4'd7;
        edge_chk("loop_a", 4'd7, 8'h78);
        edge_chk("loop_b", 4'd7, 8'h78);
        edge_chk("loop_c", 4'd7, 8'h78);
        #2 rst = 1'b0;
        #1 pc_ins("async_rst", 4'd0, 8'h0F);

        branchaddress = 4'd9;
        edge_chk("hold_a", 4'd0, 8'h0F);
        edge_chk("hold_b", 4'd0, 8'h0F);
        edge_chk("hold_c", 4'd0, 8'h0F);
        rst = 1'b1;
        edge_chk("rel_br9", 4'd9, 8'h96);
        branch = 1'b0;
        edge_chk("rel_cnt", 4'd10, 8'hA5);
        edge_chk("cnt11", 4'd11, 8'hB4);
        edge_chk("cnt12", 4'd12, 8'hC3);
        edge_chk("cnt13", 4'd13, 8'hD2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter ADDR_W, default 4, width of program counter and branch address; depth = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 8, instruction word width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 branch  input  1  when 1, next PC is loaded from branchaddress instead of incrementing.
REQ-006 branchaddress  input  ADDR_W  branch target address.
REQ-007 instruction  output  DATA_W  ROM word at current PC.

Function
REQ-008 The module SHALL hold an internal ADDR_W-bit register named pc; verification probes it hierarchically as uut.pc.
REQ-009 On each rising clk with rst high and branch=1, pc SHALL load branchaddress.
REQ-010 On each rising clk with rst high and branch=0, pc SHALL load pc+1 modulo 2**ADDR_W (15 wraps to 0), with no overflow flag.
REQ-011 branch and branchaddress SHALL be sampled only at the rising edge; no setup-window or glitch behaviour is defined between edges.
REQ-012 A branch to the current pc value SHALL hold pc for that cycle (self-loop).
REQ-013 The instruction SHALL be a combinational read: instruction = ROM[pc], valid in the same cycle pc changes, with zero clock latency.
REQ-014 The ROM SHALL be read-only with fixed contents; entry i = {i[3:0], ~i[3:0]} for the default widths: 0F,1E,2D,3C,4B,5A,69,78,87,96,A5,B4,C3,D2,E1,F0 (hex, address 0..15).
REQ-015 For non-default parameters, ROM entry i SHALL be {i, ~i} truncated or zero-extended on the MSB side to DATA_W.
REQ-016 The ROM SHALL contain no X or uninitialised entries at any time.

Reset
REQ-017 rst low SHALL force pc to 0 immediately, without waiting for clk, so instruction becomes 8'h0F combinationally.
REQ-018 While rst is low, pc SHALL stay 0 regardless of clk and branch.
REQ-019 On the first rising clk after rst deasserts, pc SHALL advance normally (to 1, or to branchaddress if branch=1).
REQ-020 Reset asserted mid-run SHALL discard any pending branch and return pc to 0.

Structure
REQ-021 A shared package memory_pkg SHALL hold ADDR_W/DATA_W defaults, the pc type, and a ROM-init function returning the REQ-014 table.
REQ-022 The design SHALL use one sub-module, pc_reg (the reset/branch/increment register); the ROM lookup is inline combinational logic in memory.

Verification
REQ-023 clk period 10 ns; rst low at 3 ns and high at 13 ns -> pc=0 and instruction=0F during reset; pc then counts 1,2,3,4 on successive edges with instruction 1E,2D,3C,4B.
REQ-024 branch=1, branchaddress=2 for one edge -> pc=2 and instruction=2D on that edge; pc then resumes 3,4,5 after branch returns to 0.
REQ-025 branch=1, branchaddress=0 for one edge -> pc=0 and instruction=0F; counting then resumes from 1.
REQ-026 Let pc run from 14 -> pc reaches 15 with instruction F0, then wraps to 0 with instruction 0F.
REQ-027 Hold branch=1 with branchaddress=7 for 3 edges -> pc stays 7 and instruction stays 78; pull rst low between edges -> pc=0 immediately, with no clock edge needed.
REQ-028 Drive rst low with branch=1 and branchaddress=9 across several edges -> pc stays 0; after rst goes high, the next edge loads pc=9.
